// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle MIPS control FSM.
// Holds the state encoding, opcode values, datapath select codes and the
// packed control-bundle struct passed from the output decoder to the top.
package mc_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 6;

  typedef enum logic [STATE_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUB_REGB     = 2'b00;
  localparam logic [1:0] ALUB_FOUR     = 2'b01;
  localparam logic [1:0] ALUB_IMM      = 2'b10;
  localparam logic [1:0] ALUB_IMM_SHL2 = 2'b11;

  // Full set of datapath controls produced each cycle.
  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// Combinational control decode for the multicycle controller.
// Ports: state (current FSM state), mem_ready (memory handshake, only
// consulted in FETCH), ctrl (full control bundle for the datapath).
module mc_output_decode
  import mc_pkg::*;
(
  input  state_t mem_state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  // Everything defaults to 0; each state turns on only what it needs.
  // Unused encodings fall through with all controls (and write enables) off.
  always_comb begin
    ctrl = '0;
    case (mem_state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = ALUB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        // IR and PC only load once the instruction word is actually back.
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      DECODE: begin
        ctrl.alu_src_b = ALUB_IMM_SHL2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEMRD: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_REGB;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_REGB;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.branch    = 1'b1;
        ctrl.pc_src    = PCSRC_ALUOUT;
      end
      ADDIEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCSRC_JUMP;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle MIPS datapath.
// Ports: clk, rst_n (async active-low), opcode (IR[31:26]), mem_ready
// (shared memory handshake); outputs are the datapath enables/selects,
// the sticky illegal_op flag and state_dbg (registered state).
module multicycle_controller
  import mc_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                branch,
  output logic [1:0]          pc_src,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                illegal_op,
  output logic [STATE_W-1:0]  state_dbg
);

  state_t state;
  state_t next_state;
  logic   illegal_set_c;
  logic   illegal_q;
  ctrl_t  ctrl_c;
  ctrl_t  ctrl_gated;

  // State register and sticky illegal-opcode flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= next_state;
      if (illegal_set_c) illegal_q <= 1'b1;
    end
  end

  // Next-state logic; opcode is only meaningful in DECODE and MEMADR.
  always_comb begin
    next_state    = FETCH;
    illegal_set_c = 1'b0;
    case (state)
      FETCH:    next_state = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = EXECUTE;
          OP_BEQ:       next_state = BRANCH;
          OP_ADDI:      next_state = ADDIEXEC;
          OP_J:         next_state = JUMP;
          default: begin
            // PC already advanced in FETCH, so the bad word is just skipped.
            next_state    = FETCH;
            illegal_set_c = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        if (opcode == OP_LW)      next_state = MEMRD;
        else if (opcode == OP_SW) next_state = MEMWR;
        else                      next_state = FETCH;
      end
      MEMRD:    next_state = mem_ready ? MEMWB : MEMRD;
      MEMWB:    next_state = FETCH;
      MEMWR:    next_state = mem_ready ? FETCH : MEMWR;
      EXECUTE:  next_state = ALUWB;
      ALUWB:    next_state = FETCH;
      BRANCH:   next_state = FETCH;
      ADDIEXEC: next_state = ADDIWB;
      ADDIWB:   next_state = FETCH;
      JUMP:     next_state = FETCH;
      default:  next_state = FETCH;
    endcase
  end

  mc_output_decode u_decode (
    .mem_state (state),
    .mem_ready (mem_ready),
    .ctrl      (ctrl_c)
  );

  // Reset state is FETCH, which would otherwise raise mem_read; hold every
  // control low for as long as rst_n is asserted.
  assign ctrl_gated = rst_n ? ctrl_c : '0;

  assign pc_write   = ctrl_gated.pc_write;
  assign branch     = ctrl_gated.branch;
  assign pc_src     = ctrl_gated.pc_src;
  assign iord       = ctrl_gated.iord;
  assign mem_read   = ctrl_gated.mem_read;
  assign mem_write  = ctrl_gated.mem_write;
  assign ir_write   = ctrl_gated.ir_write;
  assign reg_dst    = ctrl_gated.reg_dst;
  assign mem_to_reg = ctrl_gated.mem_to_reg;
  assign reg_write  = ctrl_gated.reg_write;
  assign alu_src_a  = ctrl_gated.alu_src_a;
  assign alu_src_b  = ctrl_gated.alu_src_b;
  assign alu_op     = ctrl_gated.alu_op;
  assign illegal_op = illegal_q;
  assign state_dbg  = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller.
module tb_multicycle_controller;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, branch, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic [3:0] state_dbg;
  logic [15:0] ctrl;

  int n_checks = 0;
  int n_fails  = 0;

  multicycle_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .branch     (branch),
    .pc_src     (pc_src),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .illegal_op (illegal_op),
    .state_dbg  (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ctrl = {pc_write, branch, pc_src, iord, mem_read, mem_write, ir_write,
                 reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op};

  // Field order: pcw br pc_src iord mr mw irw rd m2r rw asa asb aop
  localparam logic [15:0] C_ZERO    = 16'b0_0_00_0_0_0_0_0_0_0_0_00_00;
  localparam logic [15:0] C_FETCH   = 16'b1_0_00_0_1_0_1_0_0_0_0_01_00;
  localparam logic [15:0] C_FWAIT   = 16'b0_0_00_0_1_0_0_0_0_0_0_01_00;
  localparam logic [15:0] C_DECODE  = 16'b0_0_00_0_0_0_0_0_0_0_0_11_00;
  localparam logic [15:0] C_MEMADR  = 16'b0_0_00_0_0_0_0_0_0_0_1_10_00;
  localparam logic [15:0] C_MEMRD   = 16'b0_0_00_1_1_0_0_0_0_0_0_00_00;
  localparam logic [15:0] C_MEMWB   = 16'b0_0_00_0_0_0_0_0_1_1_0_00_00;
  localparam logic [15:0] C_MEMWR   = 16'b0_0_00_1_0_1_0_0_0_0_0_00_00;
  localparam logic [15:0] C_EXEC    = 16'b0_0_00_0_0_0_0_0_0_0_1_00_10;
  localparam logic [15:0] C_ALUWB   = 16'b0_0_00_0_0_0_0_1_0_1_0_00_00;
  localparam logic [15:0] C_BRANCH  = 16'b0_1_01_0_0_0_0_0_0_0_1_00_01;
  localparam logic [15:0] C_ADDIEX  = 16'b0_0_00_0_0_0_0_0_0_0_1_10_00;
  localparam logic [15:0] C_ADDIWB  = 16'b0_0_00_0_0_0_0_0_0_1_0_00_00;
  localparam logic [15:0] C_JUMP    = 16'b1_0_10_0_0_0_0_0_0_0_0_00_00;

  // Check the current cycle at the falling edge, then move to just after
  // the next rising edge so the caller can change inputs for the next cycle.
  task automatic cyc(input string tag, input logic [3:0] es,
                     input logic [15:0] ec, input logic eill);
    @(negedge clk);
    n_checks++;
    assert (state_dbg === es) else begin
      n_fails++;
      $error("FAIL %s state: observed %0d expected %0d", tag, state_dbg, es);
    end
    n_checks++;
    assert (ctrl === ec) else begin
      n_fails++;
      $error("FAIL %s ctrl: observed %b expected %b", tag, ctrl, ec);
    end
    n_checks++;
    assert (illegal_op === eill) else begin
      n_fails++;
      $error("FAIL %s illegal_op: observed %b expected %b", tag, illegal_op, eill);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    opcode    = 6'b000000;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cyc("reset", 4'd0, C_ZERO, 1'b0);
    rst_n = 1'b1;

    // LW, memory always ready: 0,1,2,3,4 then FETCH
    opcode = 6'b100011;
    cyc("lw_fetch",  4'd0, C_FETCH,  1'b0);
    cyc("lw_decode", 4'd1, C_DECODE, 1'b0);
    cyc("lw_memadr", 4'd2, C_MEMADR, 1'b0);
    cyc("lw_memrd",  4'd3, C_MEMRD,  1'b0);
    cyc("lw_memwb",  4'd4, C_MEMWB,  1'b0);

    // R-type with one FETCH stall cycle
    opcode    = 6'b000000;
    mem_ready = 1'b0;
    cyc("r_fwait",   4'd0, C_FWAIT,  1'b0);
    mem_ready = 1'b1;
    cyc("r_fetch",   4'd0, C_FETCH,  1'b0);
    cyc("r_decode",  4'd1, C_DECODE, 1'b0);
    cyc("r_exec",    4'd6, C_EXEC,   1'b0);
    cyc("r_aluwb",   4'd7, C_ALUWB,  1'b0);

    // BEQ
    opcode = 6'b000100;
    cyc("beq_fetch",  4'd0, C_FETCH,  1'b0);
    cyc("beq_decode", 4'd1, C_DECODE, 1'b0);
    cyc("beq_branch", 4'd8, C_BRANCH, 1'b0);

    // J
    opcode = 6'b000010;
    cyc("j_fetch",  4'd0,  C_FETCH,  1'b0);
    cyc("j_decode", 4'd1,  C_DECODE, 1'b0);
    cyc("j_jump",   4'd11, C_JUMP,   1'b0);

    // SW with mem_ready low for 3 MEMWR cycles (also low through MEMADR,
    // where it must be ignored)
    opcode = 6'b101011;
    cyc("sw_fetch",  4'd0, C_FETCH,  1'b0);
    cyc("sw_decode", 4'd1, C_DECODE, 1'b0);
    mem_ready = 1'b0;
    cyc("sw_memadr", 4'd2, C_MEMADR, 1'b0);
    cyc("sw_wr0",    4'd5, C_MEMWR,  1'b0);
    cyc("sw_wr1",    4'd5, C_MEMWR,  1'b0);
    cyc("sw_wr2",    4'd5, C_MEMWR,  1'b0);
    mem_ready = 1'b1;
    cyc("sw_wr3",    4'd5, C_MEMWR,  1'b0);

    // Illegal opcode: 2 cycles, flag appears after DECODE
    opcode = 6'b111111;
    cyc("ill_fetch",  4'd0, C_FETCH,  1'b0);
    cyc("ill_decode", 4'd1, C_DECODE, 1'b0);

    // ADDI with the sticky flag still set
    opcode = 6'b001000;
    cyc("addi_fetch",  4'd0,  C_FETCH,  1'b1);
    cyc("addi_decode", 4'd1,  C_DECODE, 1'b1);
    cyc("addi_exec",   4'd9,  C_ADDIEX, 1'b1);
    cyc("addi_wb",     4'd10, C_ADDIWB, 1'b1);

    // LW stalled in MEMRD, then reset mid-access
    opcode = 6'b100011;
    cyc("lw2_fetch",  4'd0, C_FETCH,  1'b1);
    cyc("lw2_decode", 4'd1, C_DECODE, 1'b1);
    cyc("lw2_memadr", 4'd2, C_MEMADR, 1'b1);
    mem_ready = 1'b0;
    cyc("lw2_rd0",    4'd3, C_MEMRD,  1'b1);
    rst_n = 1'b0;
    cyc("mid_reset",  4'd0, C_ZERO,   1'b0);
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    cyc("post_fetch",  4'd0, C_FETCH,  1'b0);
    cyc("post_decode", 4'd1, C_DECODE, 1'b0);
    cyc("post_memadr", 4'd2, C_MEMADR, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
